// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trace_pkg
// Purpose : Shared types and constants for the trace sequencer: FSM state
//           enum, default spell-trace pattern table and counter-width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHOW       = 2'd1,
    WAIT_CLEAR = 2'd2,
    DONE       = 2'd3
  } trace_state_t;

  localparam int NUM_PATS = 30;

  localparam logic [15:0] TRACE_PAT_0  = 16'h0231;
  localparam logic [15:0] TRACE_PAT_1  = 16'h0075;
  localparam logic [15:0] TRACE_PAT_2  = 16'h8ca9;
  localparam logic [15:0] TRACE_PAT_3  = 16'h8f23;
  localparam logic [15:0] TRACE_PAT_4  = 16'hd9be;
  localparam logic [15:0] TRACE_PAT_5  = 16'h3c5a;
  localparam logic [15:0] TRACE_PAT_6  = 16'h71e4;
  localparam logic [15:0] TRACE_PAT_7  = 16'ha5c3;
  localparam logic [15:0] TRACE_PAT_8  = 16'h1f08;
  localparam logic [15:0] TRACE_PAT_9  = 16'h6b92;
  localparam logic [15:0] TRACE_PAT_10 = 16'hc437;
  localparam logic [15:0] TRACE_PAT_11 = 16'h2ed1;
  localparam logic [15:0] TRACE_PAT_12 = 16'h9a6c;
  localparam logic [15:0] TRACE_PAT_13 = 16'h5713;
  localparam logic [15:0] TRACE_PAT_14 = 16'he0b5;
  localparam logic [15:0] TRACE_PAT_15 = 16'h48fd;
  localparam logic [15:0] TRACE_PAT_16 = 16'hb36e;
  localparam logic [15:0] TRACE_PAT_17 = 16'h0dc9;
  localparam logic [15:0] TRACE_PAT_18 = 16'h7a21;
  localparam logic [15:0] TRACE_PAT_19 = 16'hf584;
  localparam logic [15:0] TRACE_PAT_20 = 16'h3e97;
  localparam logic [15:0] TRACE_PAT_21 = 16'h8b5d;
  localparam logic [15:0] TRACE_PAT_22 = 16'h64a0;
  localparam logic [15:0] TRACE_PAT_23 = 16'hd12b;
  localparam logic [15:0] TRACE_PAT_24 = 16'h29f6;
  localparam logic [15:0] TRACE_PAT_25 = 16'hae43;
  localparam logic [15:0] TRACE_PAT_26 = 16'h5c8e;
  localparam logic [15:0] TRACE_PAT_27 = 16'h17b9;
  localparam logic [15:0] TRACE_PAT_28 = 16'hc6d2;
  localparam logic [15:0] TRACE_PAT_29 = 16'h934f;

  // Width needed to count 0..num_traces inclusive.
  function automatic int cnt_w(input int num_traces);
    return $clog2(num_traces + 1);
  endfunction

  // Games longer than the table reuse it cyclically so no target is ever 0.
  function automatic logic [15:0] trace_pat(input int idx);
    case (idx % NUM_PATS)
      0:  return TRACE_PAT_0;
      1:  return TRACE_PAT_1;
      2:  return TRACE_PAT_2;
      3:  return TRACE_PAT_3;
      4:  return TRACE_PAT_4;
      5:  return TRACE_PAT_5;
      6:  return TRACE_PAT_6;
      7:  return TRACE_PAT_7;
      8:  return TRACE_PAT_8;
      9:  return TRACE_PAT_9;
      10: return TRACE_PAT_10;
      11: return TRACE_PAT_11;
      12: return TRACE_PAT_12;
      13: return TRACE_PAT_13;
      14: return TRACE_PAT_14;
      15: return TRACE_PAT_15;
      16: return TRACE_PAT_16;
      17: return TRACE_PAT_17;
      18: return TRACE_PAT_18;
      19: return TRACE_PAT_19;
      20: return TRACE_PAT_20;
      21: return TRACE_PAT_21;
      22: return TRACE_PAT_22;
      23: return TRACE_PAT_23;
      24: return TRACE_PAT_24;
      25: return TRACE_PAT_25;
      26: return TRACE_PAT_26;
      27: return TRACE_PAT_27;
      28: return TRACE_PAT_28;
      default: return TRACE_PAT_29;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_pattern_rom.sv
`default_nettype none
// ============================================================================
// Module  : trace_pattern_rom
// Purpose : Asynchronous-read constant table of target trace patterns.
//           Indices at or beyond NUM_TRACES read as 0.
// Ports   : idx     in  IDX_W    pattern index
//           pattern out TRACE_W  pattern at idx
// Revision: 1.0 - initial release
// ============================================================================
module trace_pattern_rom
  import trace_pkg::*;
#(
  parameter int TRACE_W    = 16,
  parameter int NUM_TRACES = 20,
  parameter int IDX_W      = cnt_w(NUM_TRACES)
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [TRACE_W-1:0] pattern
);

  always_comb begin
    pattern = '0;
    if (int'(idx) < NUM_TRACES) pattern = TRACE_W'(trace_pat(int'(idx)));
  end

endmodule
`default_nettype wire

// File: rtl/trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : trace_sequencer
// Purpose : N-player spell-trace sequencer. Presents ROM targets in order,
//           awards a point to the lowest-index enabled player whose trace
//           covers the target, and registers a winner at game end.
//           Optional per-pattern timeout: define TRACE_TIMEOUT_EN.
// Ports   : clk, reset_n (async, active-low)
//           trace_screen_on          game-active level (low pauses / ends)
//           player_en                per-player enable
//           player_traced            packed traced bitmaps
//           trace_to_display         current target (0 in DONE)
//           previous_trace_displayed last completed target
//           trace_count              patterns completed
//           player_score             packed per-player scores
//           match_pulse / timeout_pulse  one-cycle advance indicators
//           end_game_early           high in DONE
//           winner_id                registered winner index
// Revision: 1.0 - initial release
// ============================================================================
module trace_sequencer
  import trace_pkg::*;
#(
  parameter  int TRACE_W     = 16,
  parameter  int NUM_TRACES  = 20,
  parameter  int NUM_PLAYERS = 2,
  parameter  int TIMEOUT_CYC = 50_000_000,
  localparam int CNT_W       = cnt_w(NUM_TRACES),
  localparam int WIN_W       = $clog2(NUM_PLAYERS) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           trace_screen_on,
  input  logic [NUM_PLAYERS-1:0]         player_en,
  input  logic [NUM_PLAYERS*TRACE_W-1:0] player_traced,
  output logic [TRACE_W-1:0]             trace_to_display,
  output logic [TRACE_W-1:0]             previous_trace_displayed,
  output logic [CNT_W-1:0]               trace_count,
  output logic [NUM_PLAYERS*CNT_W-1:0]   player_score,
  output logic                           match_pulse,
  output logic                           timeout_pulse,
  output logic                           end_game_early,
  output logic [WIN_W-1:0]               winner_id
);

  trace_state_t     state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] score     [NUM_PLAYERS];
  logic [CNT_W-1:0] score_nxt [NUM_PLAYERS];
  logic [CNT_W-1:0] best_score;
  logic [TRACE_W-1:0] target, prev_nxt;
  logic [WIN_W-1:0] win_nxt;
  logic             match_nxt, tmo_nxt;
  logic             hit, all_clear, timeout_hit;
  int               hit_idx, best;

  // The ROM is addressed directly by the completed-pattern count, so the
  // next target appears on the same edge that bumps the count.
  trace_pattern_rom #(
    .TRACE_W   (TRACE_W),
    .NUM_TRACES(NUM_TRACES),
    .IDX_W     (CNT_W)
  ) u_rom (
    .idx    (trace_count),
    .pattern(target)
  );

  assign trace_to_display = (state == DONE) ? '0 : target;
  assign end_game_early   = (state == DONE);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign player_score[g*CNT_W +: CNT_W] = score[g];
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = 0;
    all_clear = 1'b1;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (player_en[i]) begin
        if (player_traced[i*TRACE_W +: TRACE_W] != '0) all_clear = 1'b0;
        if (((player_traced[i*TRACE_W +: TRACE_W] & target) == target) && (target != '0)) begin
          hit     = 1'b1;
          hit_idx = i;
        end
      end
    end
  end

`ifdef TRACE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_hit = (state == SHOW) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Counts active SHOW cycles only; held while paused, cleared elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               tmo_cnt <= '0;
    else if (state != SHOW)     tmo_cnt <= '0;
    else if (trace_screen_on)   tmo_cnt <= timeout_hit ? '0 : tmo_cnt + TMO_W'(1);
  end
`else
  // No timeout hardware in this build; the period parameter has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_nxt  = state;
    count_nxt  = trace_count;
    prev_nxt   = previous_trace_displayed;
    win_nxt    = winner_id;
    match_nxt  = 1'b0;
    tmo_nxt    = 1'b0;
    best       = 0;
    best_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) score_nxt[i] = score[i];

    case (state)
      IDLE: begin
        if (trace_screen_on) begin
          state_nxt = SHOW;
          count_nxt = '0;
          win_nxt   = '0;
          for (int i = 0; i < NUM_PLAYERS; i++) score_nxt[i] = '0;
        end
      end
      SHOW: begin
        // A simultaneous match wins over a timeout.
        if (trace_screen_on && (hit || timeout_hit)) begin
          count_nxt = trace_count + CNT_W'(1);
          prev_nxt  = target;
          if (hit) begin
            match_nxt = 1'b1;
            for (int i = 0; i < NUM_PLAYERS; i++)
              if ((i == hit_idx) && (score[i] < CNT_W'(NUM_TRACES)))
                score_nxt[i] = score[i] + CNT_W'(1);
          end else begin
            tmo_nxt = 1'b1;
          end
          state_nxt = (count_nxt == CNT_W'(NUM_TRACES)) ? DONE : WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: if (trace_screen_on && all_clear) state_nxt = SHOW;
      DONE:       if (!trace_screen_on) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase

    // Winner uses the post-match scores so the final point counts.
    if ((state_nxt == DONE) && (state != DONE)) begin
      best_score = score_nxt[0];
      for (int i = 1; i < NUM_PLAYERS; i++) begin
        if (score_nxt[i] > best_score) begin
          best_score = score_nxt[i];
          best       = i;
        end
      end
      win_nxt = WIN_W'(best);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= IDLE;
      trace_count              <= '0;
      previous_trace_displayed <= '0;
      match_pulse              <= 1'b0;
      timeout_pulse            <= 1'b0;
      winner_id                <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else begin
      state                    <= state_nxt;
      trace_count              <= count_nxt;
      previous_trace_displayed <= prev_nxt;
      match_pulse              <= match_nxt;
      timeout_pulse            <= tmo_nxt;
      winner_id                <= win_nxt;
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= score_nxt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_sequencer
// Purpose : Self-checking bench for trace_sequencer (directed scenarios plus
//           randomized play against a game-rule reference model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_trace_sequencer;
  localparam int TW = 16;
  localparam int NT = 20;
  localparam int NP = 2;
  localparam int CW = $clog2(NT + 1);
  localparam int WW = $clog2(NP) + 1;
`ifdef TRACE_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_ON = 1'b1;
`else
  localparam int TMO    = 50_000_000;
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic trace_screen_on = 1'b0;
  logic [NP-1:0] player_en = '0;
  logic [NP*TW-1:0] player_traced = '0;
  logic [TW-1:0] trace_to_display, previous_trace_displayed;
  logic [CW-1:0] trace_count;
  logic [NP*CW-1:0] player_score;
  logic match_pulse, timeout_pulse, end_game_early;
  logic [WW-1:0] winner_id;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] pats [30] = '{16'h0231, 16'h0075, 16'h8ca9, 16'h8f23, 16'hd9be,
                             16'h3c5a, 16'h71e4, 16'ha5c3, 16'h1f08, 16'h6b92,
                             16'hc437, 16'h2ed1, 16'h9a6c, 16'h5713, 16'he0b5,
                             16'h48fd, 16'hb36e, 16'h0dc9, 16'h7a21, 16'hf584,
                             16'h3e97, 16'h8b5d, 16'h64a0, 16'hd12b, 16'h29f6,
                             16'hae43, 16'h5c8e, 16'h17b9, 16'hc6d2, 16'h934f};

  // Reference model: game phase 0=idle 1=showing 2=awaiting clear 3=over.
  int m_phase, m_count, m_wait, m_win;
  int m_score [NP];
  logic [15:0] m_prev;
  bit m_match, m_tmo;

  trace_sequencer #(
    .TRACE_W(TW), .NUM_TRACES(NT), .NUM_PLAYERS(NP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trace_screen_on(trace_screen_on),
    .player_en(player_en), .player_traced(player_traced),
    .trace_to_display(trace_to_display),
    .previous_trace_displayed(previous_trace_displayed),
    .trace_count(trace_count), .player_score(player_score),
    .match_pulse(match_pulse), .timeout_pulse(timeout_pulse),
    .end_game_early(end_game_early), .winner_id(winner_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pat(input int i);
    if (i < 0 || i >= NT) return 16'h0;
    return pats[i % 30];
  endfunction

  function automatic logic [15:0] exp_target();
    return (m_phase == 3) ? 16'h0 : pat(m_count);
  endfunction

  function automatic logic [CW-1:0] dscore(input int i);
    return player_score[i*CW +: CW];
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_count = 0; m_wait = 0; m_win = 0; m_prev = '0;
    m_match = 0; m_tmo = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endfunction

  function automatic void model_step(input bit on, input logic [NP-1:0] en,
                                     input logic [NP*TW-1:0] tr);
    logic [15:0] tgt;
    int who, top;
    bit clear;
    m_match = 0; m_tmo = 0;
    case (m_phase)
      0: if (on) begin
        m_phase = 1; m_count = 0; m_win = 0; m_wait = 0;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
      end
      1: if (on) begin
        tgt = pat(m_count);
        who = -1;
        if (tgt != 0)
          for (int i = 0; i < NP; i++)
            if (who < 0 && en[i] && ((tr[i*TW +: TW] & tgt) == tgt)) who = i;
        if (who >= 0 || (TMO_ON && m_wait == TMO - 1)) begin
          m_prev = tgt;
          m_count++;
          if (who >= 0) begin
            m_match = 1;
            if (m_score[who] < NT) m_score[who]++;
          end else m_tmo = 1;
          if (m_count == NT) begin
            m_phase = 3;
            top = 0;
            for (int i = 1; i < NP; i++) if (m_score[i] > m_score[top]) top = i;
            m_win = top;
          end else m_phase = 2;
        end else m_wait++;
      end
      2: begin
        clear = 1;
        for (int i = 0; i < NP; i++) if (en[i] && tr[i*TW +: TW] != 0) clear = 0;
        if (on && clear) begin m_phase = 1; m_wait = 0; end
      end
      default: if (!on) m_phase = 0;
    endcase
  endfunction

  task automatic drive(input bit on, input logic [NP-1:0] en,
                       input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    trace_screen_on = on;
    player_en = en;
    player_traced = {t1, t0};
    @(posedge clk);
    model_step(on, en, {t1, t0});
    #1;
  endtask

  task automatic do_reset();
    trace_screen_on = 0; player_en = '0; player_traced = '0;
    reset_n = 0;
    model_reset();
    #7;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    trace_screen_on = 0; player_en = '0; player_traced = '0;
    reset_n = 0;
    model_reset();
    #12;
    vectors++; if (trace_count !== 0) begin miscompares++; $display("FAIL reset_count: got %0d required 0", trace_count); end
    vectors++; if (trace_to_display !== 16'h0231) begin miscompares++; $display("FAIL reset_target: got %h required 0231", trace_to_display); end
    vectors++; if (previous_trace_displayed !== 0) begin miscompares++; $display("FAIL reset_prev: got %h required 0", previous_trace_displayed); end
    vectors++; if (player_score !== 0) begin miscompares++; $display("FAIL reset_scores: got %h required 0", player_score); end
    vectors++; if ({match_pulse, timeout_pulse, end_game_early} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b required 000", {match_pulse, timeout_pulse, end_game_early}); end
    vectors++; if (winner_id !== 0) begin miscompares++; $display("FAIL reset_winner: got %0d required 0", winner_id); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_first_match();
    drive(1, 2'b11, 16'h0, 16'h0);
    drive(1, 2'b11, 16'h0231, 16'h0);
    vectors++; if (trace_count !== 1) begin miscompares++; $display("FAIL first_count: got %0d required 1", trace_count); end
    vectors++; if (dscore(0) !== 1) begin miscompares++; $display("FAIL first_score0: got %0d required 1", dscore(0)); end
    vectors++; if (trace_to_display !== 16'h0075) begin miscompares++; $display("FAIL first_target: got %h required 0075", trace_to_display); end
    vectors++; if (previous_trace_displayed !== 16'h0231) begin miscompares++; $display("FAIL first_prev: got %h required 0231", previous_trace_displayed); end
    vectors++; if (match_pulse !== 1) begin miscompares++; $display("FAIL first_pulse: got %b required 1", match_pulse); end
  endtask

  task automatic test_hold_clear();
    for (int c = 0; c < 4; c++) begin
      drive(1, 2'b11, 16'hFFFF, 16'h0);
      vectors++; if (trace_count !== 1 || match_pulse !== 0) begin miscompares++; $display("FAIL hold_no_advance: got count %0d pulse %b required 1 0", trace_count, match_pulse); end
    end
    drive(1, 2'b11, 16'h0, 16'h0);
    drive(1, 2'b11, 16'h0075, 16'h0);
    vectors++; if (trace_count !== 2 || dscore(0) !== 2) begin miscompares++; $display("FAIL hold_advance: got count %0d score %0d required 2 2", trace_count, dscore(0)); end
    vectors++; if (trace_to_display !== 16'h8ca9) begin miscompares++; $display("FAIL hold_target: got %h required 8ca9", trace_to_display); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 2'b11, 16'h0, 16'h0);
    drive(1, 2'b11, 16'h0231, 16'h0231);
    vectors++; if (dscore(0) !== 1 || dscore(1) !== 0 || trace_count !== 1) begin miscompares++; $display("FAIL simultaneous: got s0 %0d s1 %0d count %0d required 1 0 1", dscore(0), dscore(1), trace_count); end
  endtask

  task automatic test_enable();
    drive(1, 2'b11, 16'h0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 2'b01, 16'h0, 16'h0075);
      vectors++; if (trace_count !== 1 || dscore(1) !== 0) begin miscompares++; $display("FAIL disabled_player: got count %0d s1 %0d required 1 0", trace_count, dscore(1)); end
    end
    drive(1, 2'b11, 16'h0, 16'h0075);
    vectors++; if (trace_count !== 2 || dscore(1) !== 1) begin miscompares++; $display("FAIL enabled_player: got count %0d s1 %0d required 2 1", trace_count, dscore(1)); end
  endtask

  task automatic test_full_game();
    do_reset();
    drive(1, 2'b11, 16'h0, 16'h0);
    for (int k = 0; k < NT; k++) begin
      if (k < 11) drive(1, 2'b11, 16'h0, pat(k));
      else        drive(1, 2'b11, pat(k), 16'h0);
      drive(1, 2'b11, 16'h0, 16'h0);
    end
    vectors++; if (end_game_early !== 1 || trace_to_display !== 0) begin miscompares++; $display("FAIL game_done: got end %b target %h required 1 0000", end_game_early, trace_to_display); end
    vectors++; if (winner_id !== 1) begin miscompares++; $display("FAIL game_winner: got %0d required 1", winner_id); end
    vectors++; if (dscore(0) !== 9 || dscore(1) !== 11 || trace_count !== NT) begin miscompares++; $display("FAIL game_scores: got %0d %0d count %0d required 9 11 20", dscore(0), dscore(1), trace_count); end
    drive(0, 2'b11, 16'h0, 16'h0);
    vectors++; if (end_game_early !== 0) begin miscompares++; $display("FAIL game_to_idle: got end %b required 0", end_game_early); end
    drive(1, 2'b11, 16'h0, 16'h0);
    vectors++; if (trace_count !== 0 || trace_to_display !== 16'h0231 || player_score !== 0 || winner_id !== 0) begin miscompares++; $display("FAIL game_restart: got count %0d target %h scores %h win %0d required 0 0231 0 0", trace_count, trace_to_display, player_score, winner_id); end
  endtask

  task automatic test_pause();
    do_reset();
    drive(1, 2'b11, 16'h0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 2'b11, 16'h0231, 16'h0);
      vectors++; if (trace_count !== 0 || match_pulse !== 0) begin miscompares++; $display("FAIL pause_hold: got count %0d pulse %b required 0 0", trace_count, match_pulse); end
    end
    drive(1, 2'b11, 16'h0231, 16'h0);
    vectors++; if (trace_count !== 1 || match_pulse !== 1) begin miscompares++; $display("FAIL pause_resume: got count %0d pulse %b required 1 1", trace_count, match_pulse); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 2'b11, 16'h0, 16'h0);
    drive(1, 2'b11, 16'h0231, 16'h0);
    drive(1, 2'b11, 16'h0, 16'h0);
    drive(1, 2'b11, 16'h0, 16'h0075);
    reset_n = 0;
    #2;
    vectors++; if (trace_count !== 0 || trace_to_display !== 16'h0231 || previous_trace_displayed !== 0) begin miscompares++; $display("FAIL async_reset_regs: got count %0d target %h prev %h required 0 0231 0000", trace_count, trace_to_display, previous_trace_displayed); end
    vectors++; if (player_score !== 0 || match_pulse !== 0 || end_game_early !== 0) begin miscompares++; $display("FAIL async_reset_flags: got scores %h pulse %b end %b required 0 0 0", player_score, match_pulse, end_game_early); end
    model_reset();
    trace_screen_on = 0; player_en = '0; player_traced = '0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 2'b11, 16'h0, 16'h0);
`ifdef TRACE_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      drive(1, 2'b11, 16'h0, 16'h0);
      vectors++; if (timeout_pulse !== (c == 8)) begin miscompares++; $display("FAIL timeout_cycle%0d: got %b required %b", c, timeout_pulse, c == 8); end
    end
    vectors++; if (trace_count !== 1 || player_score !== 0 || match_pulse !== 0) begin miscompares++; $display("FAIL timeout_advance: got count %0d scores %h match %b required 1 0 0", trace_count, player_score, match_pulse); end
    drive(1, 2'b11, 16'h0, 16'h0);
    for (int c = 1; c <= 3; c++) drive(1, 2'b11, 16'h0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 2'b11, 16'h0, 16'h0);
      vectors++; if (timeout_pulse !== 0) begin miscompares++; $display("FAIL timeout_paused: got %b required 0", timeout_pulse); end
    end
    for (int c = 4; c <= 8; c++) begin
      drive(1, 2'b11, 16'h0, 16'h0);
      vectors++; if (timeout_pulse !== (c == 8)) begin miscompares++; $display("FAIL timeout_delayed%0d: got %b required %b", c, timeout_pulse, c == 8); end
    end
    vectors++; if (trace_count !== 2) begin miscompares++; $display("FAIL timeout_second: got %0d required 2", trace_count); end
`else
    for (int c = 0; c < 12; c++) begin
      drive(1, 2'b11, 16'h0, 16'h0);
      vectors++; if (timeout_pulse !== 0 || trace_count !== 0) begin miscompares++; $display("FAIL no_timeout: got pulse %b count %0d required 0 0", timeout_pulse, trace_count); end
    end
`endif
  endtask

  task automatic test_random();
    logic [TW-1:0] t [NP];
    logic [15:0] tgt;
    bit on;
    logic [NP-1:0] en;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      tgt = exp_target();
      on = ($urandom_range(0, 15) != 0);
      en = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 5))
          2, 3:    t[i] = tgt | (16'($urandom) & 16'h0101);
          4:       t[i] = 16'($urandom);
          5:       t[i] = 16'hFFFF;
          default: t[i] = 16'h0;
        endcase
      end
      drive(on, en, t[0], t[1]);
      vectors++;
      if (trace_count !== CW'(m_count) || trace_to_display !== exp_target() ||
          previous_trace_displayed !== m_prev || dscore(0) !== CW'(m_score[0]) ||
          dscore(1) !== CW'(m_score[1]) || match_pulse !== m_match ||
          timeout_pulse !== m_tmo || end_game_early !== (m_phase == 3) ||
          winner_id !== WW'(m_win)) begin
        miscompares++;
        $display("FAIL random_step%0d: got cnt %0d tgt %h prev %h s %0d/%0d m %b t %b e %b w %0d required cnt %0d tgt %h prev %h s %0d/%0d m %b t %b e %b w %0d",
                 n, trace_count, trace_to_display, previous_trace_displayed, dscore(0), dscore(1),
                 match_pulse, timeout_pulse, end_game_early, winner_id,
                 m_count, exp_target(), m_prev, m_score[0], m_score[1], m_match, m_tmo,
                 m_phase == 3, m_win);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_match();
    test_hold_clear();
    test_simultaneous();
    test_enable();
    test_full_game();
    test_pause();
    test_async_reset();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_sequencer.md
# trace_sequencer

Parametrised multi-player spell-trace sequencer for the trace screen. It presents a fixed sequence of target trace patterns from a pattern ROM and accepts a match from any enabled player whose traced bitmap covers the current target. It keeps per-player scores and signals game completion with a registered winner. It sits between the per-player trace capture logic and the display/game-control FSM, and is the N-player, configurable-length successor of the two-player trace changer.

## Interface
- TRACE_W, 16, width of one trace bitmap.
- NUM_TRACES, 20, number of patterns in one game (2..64).
- NUM_PLAYERS, 2, number of player trace inputs (1..8).
- TIMEOUT_CYC, 50_000_000, cycles allowed per pattern (used only with TRACE_TIMEOUT_EN).
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trace_screen_on  in  1  game-active level; low pauses or ends the game.
- player_en  in  NUM_PLAYERS  per-player enable (bit 0 = player 1).
- player_traced  in  NUM_PLAYERS*TRACE_W  packed traced bitmaps; player i occupies [i*TRACE_W +: TRACE_W].
- trace_to_display  out  TRACE_W  current target pattern.
- previous_trace_displayed  out  TRACE_W  last completed target.
- trace_count  out  CNT_W  patterns completed; CNT_W = $clog2(NUM_TRACES+1).
- player_score  out  NUM_PLAYERS*CNT_W  packed per-player match counts.
- match_pulse  out  1  one-cycle pulse on an accepted match.
- timeout_pulse  out  1  one-cycle pulse on a pattern timeout.
- end_game_early  out  1  high while in DONE.
- winner_id  out  $clog2(NUM_PLAYERS)+1  registered winner index; valid while end_game_early is high.

## Operation
- FSM states are IDLE, SHOW, WAIT_CLEAR, and DONE.
- Reset values:
  - state = IDLE, trace_count = 0, trace_to_display = rom[0].
  - previous_trace_displayed = 0, all scores = 0, pulses = 0, end_game_early = 0, winner_id = 0.
- IDLE -> SHOW when trace_screen_on = 1. Entering SHOW from IDLE clears trace_count, the scores, and winner_id, and loads rom[0].
- SHOW, match condition for player i:
  - player_en[i] = 1, and
  - (traced_i & target) == target, and
  - target != 0.
- If several players match in the same cycle, the lowest index scores. Only one point is awarded per pattern.
- On a match:
  - trace_count += 1, score[i] += 1, match_pulse = 1.
  - previous_trace_displayed = target.
  - If trace_count becomes NUM_TRACES: go to DONE. Otherwise load rom[trace_count] and go to WAIT_CLEAR.
- WAIT_CLEAR -> SHOW once every enabled player's traced input is 0. This blocks double-advancing on a held trace.
- DONE:
  - end_game_early = 1, trace_to_display = 0.
  - winner_id = highest score; ties go to the lowest index.
  - DONE -> IDLE when trace_screen_on = 0.
- trace_screen_on = 0 in SHOW or WAIT_CLEAR: all registers hold (pause) and no match is evaluated. Setting trace_screen_on = 1 again resumes from the held state.
- player_en = 0 in SHOW: no advance is possible. This is not an error.
- Scores saturate at NUM_TRACES. They cannot exceed it by construction, but the RTL guards against it anyway.

## Timing
- Match to output latency is 1 cycle:
  - inputs are sampled at edge k;
  - trace_to_display, trace_count, player_score, match_pulse, and the new state are visible after edge k.
- WAIT_CLEAR -> SHOW takes 1 cycle after all enabled inputs read 0. The earliest next match is 2 cycles after the previous one.
- winner_id is registered on the same edge as the DONE entry.
- The ROM is asynchronous-read (constant table), so there is no extra pipeline stage.
- Asserting reset_n low mid-game forces the reset values immediately, independent of clk.

## Configuration
- TRACE_TIMEOUT_EN defined:
  - A per-pattern cycle counter runs in SHOW only. It is cleared on entering SHOW and frozen while paused.
  - At TIMEOUT_CYC-1 cycles, the sequencer advances exactly like a match, except that no score changes and timeout_pulse fires instead of match_pulse.
  - The timeout advance goes to WAIT_CLEAR, or to DONE on the last pattern.
  - A match and a timeout in the same cycle count as a match.
- TRACE_TIMEOUT_EN undefined:
  - No counter is synthesised and timeout_pulse is tied to 0.

## Structure
- Package trace_pkg holds:
  - the state enum (trace_state_t);
  - the default pattern constants TRACE_PAT_0..TRACE_PAT_29 (TRACE_PAT_0 = 16'h0231, TRACE_PAT_1 = 16'h0075, TRACE_PAT_2 = 16'h8ca9, TRACE_PAT_3 = 16'h8f23, TRACE_PAT_4 = 16'hd9be, …);
  - the function clog2-based CNT_W helper.
- Sub-module trace_pattern_rom maps an index to a TRACE_W pattern. It returns 0 for indices ≥ NUM_TRACES.
- The winner comparator is a combinational loop inside trace_sequencer.

## Test plan
- Reset, then trace_screen_on = 1 and player 1 drives 16'h0231 -> after 1 cycle: trace_count = 1, score[0] = 1, trace_to_display = 16'h0075, previous = 16'h0231, match_pulse for 1 cycle.
- Player 1 holds 16'hFFFF after a match -> no further advance until the input goes to 0. Then 16'h0075 advances to trace_count = 2.
- Both players drive 16'h0231 in the same cycle -> score[0] = 1, score[1] = 0, trace_count = 1.
- Player 2 with player_en[1] = 0 drives a matching trace -> no advance. With player_en[1] = 1 -> score[1] = 1.
- Full game: player 2 wins 11 patterns and player 1 wins 9 -> DONE, end_game_early = 1, trace_to_display = 0, winner_id = 1. Dropping trace_screen_on returns to IDLE; raising it again gives trace_count = 0 and target 16'h0231.
- With TRACE_TIMEOUT_EN and TIMEOUT_CYC = 8, no input -> timeout_pulse at cycle 8, trace_count = 1, scores unchanged. Pausing trace_screen_on for 5 cycles mid-count delays the timeout by 5 cycles. Asserting reset_n low mid-game clears all outputs asynchronously.
